// File: rtl/nibble_serial_pkg.sv
// Shared constants for the nibble-serial adder: FSM encodings, nibble width
// and the two's-complement overflow rule used when the last nibble lands.
package nibble_serial_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic twos_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_adder_cin.sv
// Purely combinational 4-bit adder with carry-in; the serial datapath's only adder.
module nibble_adder_cin
    import nibble_serial_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] total;

    assign total       = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
    assign {cout, sum} = total;

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit adder: one nibble per cycle through a single 4-bit adder,
// LSB nibble first, with a one-cycle done pulse when the result is complete.
module nibble_serial_adder_ctrl
    import nibble_serial_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_amisha,
    input  logic                   rst_n_amisha,
    input  logic                   start_amisha,
    input  logic [NIB_W*NIBBLES-1:0] a_amisha,
    input  logic [NIB_W*NIBBLES-1:0] b_amisha,
    input  logic                   cin_amisha,
    output logic                   busy_amisha,
    output logic                   done_amisha,
    output logic [NIB_W*NIBBLES-1:0] sum_amisha,
    output logic                   cout_amisha,
    output logic                   ovf_amisha,
    output logic [1:0]             state_dbg_amisha
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    // Handshake: start is taken only while busy is low (IDLE); operands are
    // captured on that edge, later start pulses are dropped, and done marks
    // the single cycle in which sum/cout/ovf first hold the new result.

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
    logic             nib_cout;
    logic             last_nib;

    assign nib_a    = a_q[NIB_W*int'(idx_q) +: NIB_W];
    assign nib_b    = b_q[NIB_W*int'(idx_q) +: NIB_W];
    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    nibble_adder_cin u_nib_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_amisha) begin
                    a_d     = a_amisha;
                    b_d     = b_amisha;
                    carry_d = cin_amisha;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d[NIB_W*int'(idx_q) +: NIB_W] = nib_sum;
                carry_d = nib_cout;
                // Index holds on the last nibble so it never wraps inside ADD.
                if (last_nib) begin
                    cout_d  = nib_cout;
                    ovf_d   = twos_ovf(a_q[W-1], b_q[W-1], nib_sum[NIB_W-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_amisha      = (state_q != ST_IDLE);
    assign done_amisha      = (state_q == ST_DONE);
    assign sum_amisha       = sum_q;
    assign cout_amisha      = cout_q;
    assign ovf_amisha       = ovf_q;
    assign state_dbg_amisha = state_q;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit passes; operand width W = 4*NIBBLES.
REQ-002 clk_amisha  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n_amisha  in  1  asynchronous, active-low reset.
REQ-004 start_amisha  in  1  request to begin one W-bit addition; sampled only in IDLE.
REQ-005 a_amisha  in  W  operand A; captured on the accepted start.
REQ-006 b_amisha  in  W  operand B; captured on the accepted start.
REQ-007 cin_amisha  in  1  carry-in; captured on the accepted start.
REQ-008 busy_amisha  out  1  high whenever state is not IDLE.
REQ-009 done_amisha  out  1  single-cycle pulse: result valid.
REQ-010 sum_amisha  out  W  registered result.
REQ-011 cout_amisha  out  1  registered carry out of bit W-1.
REQ-012 ovf_amisha  out  1  registered two's-complement overflow flag.

Function
REQ-013 FSM states SHALL be IDLE, ADD, DONE.
REQ-014 IDLE: on start_amisha=1, capture a, b, cin into internal registers, clear nibble index and the sum register, go to ADD; otherwise stay.
REQ-015 ADD: each cycle, add nibble[idx] of A and B plus the carry register through one 4-bit adder, write the result into sum nibble[idx], load the carry register with the adder carry-out, increment idx.
REQ-016 ADD SHALL exit to DONE on the edge that writes nibble NIBBLES-1; idx SHALL NOT wrap inside ADD.
REQ-017 DONE: done_amisha=1 for exactly that one cycle, then return to IDLE unconditionally.
REQ-018 Latency: done_amisha SHALL be high in the cycle after the (NIBBLES+1)th rising edge counted from the edge that accepted start, i.e. after 5 edges for NIBBLES=4.
REQ-019 cout_amisha = final carry register; ovf_amisha = (A[W-1]==B[W-1]) and (sum[W-1]!=A[W-1]).
REQ-020 sum/cout/ovf SHALL be updated only by an operation and SHALL hold from done_amisha until the next accepted start.
REQ-021 start_amisha in ADD or DONE SHALL be ignored and not queued; input changes after capture SHALL NOT affect the result.
REQ-022 start in the IDLE cycle directly after DONE SHALL be accepted (back-to-back throughput NIBBLES+2 cycles).
REQ-023 Arithmetic is modulo 2^W; no saturation.

Reset
REQ-024 rst_n_amisha=0 SHALL immediately force state IDLE and busy, done, sum, cout, ovf, idx, carry and operand registers to 0, regardless of state.
REQ-025 Reset mid-operation SHALL abort it with no done pulse; the first start after release SHALL operate normally.

Structure
REQ-026 State encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) and nibble width 4 SHALL live in shared package nibble_serial_pkg.
REQ-027 One combinational sub-module nibble_adder_cin (4-bit a, b, cin -> 4-bit sum, cout) SHALL be instantiated once; the controller owns all registers.

Verification
REQ-028 a=0x0007, b=0x0000, cin=0 -> sum=0x0007, cout=0, ovf=0, done 5 edges after start, busy high for 4 cycles before it.
REQ-029 a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-030 a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0 (carry ripples across the nibble boundary).
REQ-031 start held high through the operation with a/b changed to 0x1111/0x1111 after capture -> exactly one done, result from the captured operands; next start accepted in the IDLE cycle after DONE.
REQ-032 rst_n_amisha pulsed low during the 2nd ADD cycle -> all outputs 0 at once, no done; then a=0x1234, b=0x4321 -> sum=0x5555, cout=0.
